// File: rtl/result_mem_scheduler_if.sv
// Processing-engine write port and result-memory port of result_mem_scheduler.
// The master modport is the scheduler's side; slave is the engine/memory side.
interface result_mem_scheduler_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              proc_req;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_done;
    logic              proc_start;
    logic              proc_gnt;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  proc_req, proc_addr, proc_wdata, proc_done, proc_start, mem_rdata,
        output proc_gnt, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output proc_req, proc_addr, proc_wdata, proc_done, proc_start, mem_rdata,
        input  proc_gnt, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/result_mem_scheduler.sv
// Shares the single-port result memory between the processing engine and the VGA reader.
// Optional macro TEST_PATTERN_EN: window shows an H-counter gray ramp while not in SHOW.
module result_mem_scheduler #(
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 320,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            H_Count_Value,
    input  logic [9:0]            V_Count_Value,
    result_mem_scheduler_if.master bus,
    output logic [7:0]            R,
    output logic [7:0]            G,
    output logic [7:0]            B,
    output logic                  pix_valid,
    output logic                  frame_ready
);
    typedef enum logic [1:0] {PROC, SYNC, SHOW} state_t;

    localparam logic [9:0]        WIN_W     = 10'(IMG_W);
    localparam logic [9:0]        WIN_H     = 10'(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_next;
    logic [ADDR_W-1:0] rd_base;
    logic              rd_v;
    logic              win;
    logic              fs;
    logic              win_end;
    logic [7:0]        mem_pix;

`ifdef TEST_PATTERN_EN
    logic              tp_v;
    logic [7:0]        tp_pix;
`endif

    always_comb begin
        win     = (H_Count_Value < WIN_W) && (V_Count_Value < WIN_H);
        fs      = (H_Count_Value == 10'd0) && (V_Count_Value == 10'd0);
        win_end = (H_Count_Value == 10'd0) && (V_Count_Value == WIN_H);
        mem_pix = 8'(bus.mem_rdata);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PROC;
            rd_addr <= '0;
        end else begin
            state   <= state_next;
            rd_addr <= rd_addr_next;
        end
    end

    // Frame start always reads address 0, so a misaligned read pointer recovers every frame.
    always_comb begin
        state_next    = state;
        rd_addr_next  = rd_addr;
        rd_base       = fs ? '0 : rd_addr;
        bus.proc_gnt  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        frame_ready   = 1'b0;

        case (state)
            PROC: begin
                bus.proc_gnt  = bus.proc_req;
                bus.mem_we    = bus.proc_req;
                bus.mem_addr  = bus.proc_addr;
                bus.mem_wdata = bus.proc_wdata;
                if (bus.proc_done) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (fs) begin
                    state_next   = SHOW;
                    rd_addr_next = '0;
                end
            end
            SHOW: begin
                frame_ready  = 1'b1;
                bus.mem_addr = rd_base;
                if (win) begin
                    rd_addr_next = (rd_base == LAST_ADDR) ? '0 : rd_base + 1'b1;
                end
                if (win_end && bus.proc_start) begin
                    state_next = PROC;
                end
            end
            default: begin
                state_next = PROC;
            end
        endcase

        if (!rst_n) begin
            bus.proc_gnt  = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end
    end

    // Two-cycle pixel pipeline: address in cycle t, data in t+1, registered colour in t+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v      <= 1'b0;
            R         <= 8'd0;
            G         <= 8'd0;
            B         <= 8'd0;
            pix_valid <= 1'b0;
`ifdef TEST_PATTERN_EN
            tp_v      <= 1'b0;
            tp_pix    <= 8'd0;
`endif
        end else begin
            rd_v <= win && (state == SHOW);
`ifdef TEST_PATTERN_EN
            tp_v   <= win && (state != SHOW);
            tp_pix <= H_Count_Value[7:0];
`endif
            if (rd_v) begin
                R         <= mem_pix;
                G         <= mem_pix;
                B         <= mem_pix;
                pix_valid <= 1'b1;
            end
`ifdef TEST_PATTERN_EN
            else if (tp_v) begin
                R         <= tp_pix;
                G         <= tp_pix;
                B         <= tp_pix;
                pix_valid <= 1'b1;
            end
`endif
            else begin
                R         <= 8'd0;
                G         <= 8'd0;
                B         <= 8'd0;
                pix_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_result_mem_scheduler.sv
// Directed bench for result_mem_scheduler on a reduced 40x4 window inside a 48x6 raster,
// with a registered-read memory model preloaded with mem[k] = k.
module tb_result_mem_scheduler;
    localparam int IMG_W  = 40;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int H_TOT  = 48;
    localparam int V_TOT  = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] H_Count_Value;
    logic [9:0] V_Count_Value;
    logic [7:0] R, G, B;
    logic       pix_valid;
    logic       frame_ready;
    logic       preload;
    int         h, v;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] mem [0:255];

    result_mem_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    result_mem_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .H_Count_Value(H_Count_Value),
        .V_Count_Value(V_Count_Value),
        .bus(bus),
        .R(R),
        .G(G),
        .B(B),
        .pix_valid(pix_valid),
        .frame_ready(frame_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
        H_Count_Value = 10'(h);
        V_Count_Value = 10'(v);
        #1;
    endtask

    task automatic advance_to(input int th, input int tv);
        int n;
        n = 0;
        do begin
            if (h == H_TOT - 1) begin
                h = 0;
                v = (v == V_TOT - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            tick();
            n++;
        end while (!(h == th && v == tv) && n < 2000);
        checks++;
        if (n >= 2000) begin
            $display("[TB] FAIL advance_to(%0d,%0d): cycle budget expired", th, tv);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; preload = 1'b1;
        bus.proc_req = 1'b1; bus.proc_addr = 8'd5; bus.proc_wdata = 8'hA5;
        repeat (3) tick();
        checks++; if (bus.proc_gnt !== 1'b0) begin $display("[TB] FAIL reset_gnt got %b want 0", bus.proc_gnt); errors++; end
        checks++; if (bus.mem_we !== 1'b0) begin $display("[TB] FAIL reset_we got %b want 0", bus.mem_we); errors++; end
        checks++; if (bus.mem_addr !== 8'd0) begin $display("[TB] FAIL reset_addr got %0d want 0", bus.mem_addr); errors++; end
        checks++; if (bus.mem_wdata !== 8'd0) begin $display("[TB] FAIL reset_wdata got %h want 00", bus.mem_wdata); errors++; end
        checks++; if ({R, G, B} !== 24'd0) begin $display("[TB] FAIL reset_rgb got %h want 000000", {R, G, B}); errors++; end
        checks++; if (pix_valid !== 1'b0) begin $display("[TB] FAIL reset_pv got %b want 0", pix_valid); errors++; end
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL reset_fr got %b want 0", frame_ready); errors++; end
    endtask

    task automatic test_write();
        tick();
        preload = 1'b0; rst_n = 1'b1;
        #1;
        checks++; if (bus.proc_gnt !== 1'b1) begin $display("[TB] FAIL write_gnt got %b want 1", bus.proc_gnt); errors++; end
        checks++; if (bus.mem_we !== 1'b1) begin $display("[TB] FAIL write_we got %b want 1", bus.mem_we); errors++; end
        checks++; if (bus.mem_addr !== 8'd5) begin $display("[TB] FAIL write_addr got %0d want 5", bus.mem_addr); errors++; end
        checks++; if (bus.mem_wdata !== 8'hA5) begin $display("[TB] FAIL write_wdata got %h want a5", bus.mem_wdata); errors++; end
        checks++; if (R !== 8'd0) begin $display("[TB] FAIL write_r got %h want 00", R); errors++; end
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL write_fr got %b want 0", frame_ready); errors++; end
    endtask

    task automatic test_sync();
        advance_to(12, 4);
        bus.proc_addr = 8'd7; bus.proc_wdata = 8'h77; bus.proc_done = 1'b1;
        #1;
        checks++; if (bus.proc_gnt !== 1'b1) begin $display("[TB] FAIL done_cycle_gnt got %b want 1", bus.proc_gnt); errors++; end
        advance_to(13, 4);
        bus.proc_done = 1'b0; bus.proc_addr = 8'd9; bus.proc_wdata = 8'h99;
        #1;
        checks++; if (bus.proc_gnt !== 1'b0) begin $display("[TB] FAIL sync_gnt got %b want 0", bus.proc_gnt); errors++; end
        checks++; if (bus.mem_we !== 1'b0) begin $display("[TB] FAIL sync_we got %b want 0", bus.mem_we); errors++; end
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL sync_fr got %b want 0", frame_ready); errors++; end
        advance_to(0, 0);
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL sync_fs_fr got %b want 0", frame_ready); errors++; end
        advance_to(1, 0);
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL show_entry_fr got %b want 1", frame_ready); errors++; end
        checks++; if (bus.mem_addr !== 8'd0) begin $display("[TB] FAIL show_entry_addr got %0d want 0", bus.mem_addr); errors++; end
        checks++; if (bus.proc_gnt !== 1'b0) begin $display("[TB] FAIL show_gnt got %b want 0", bus.proc_gnt); errors++; end
        bus.proc_req = 1'b0;
    endtask

    task automatic test_show();
        advance_to(0, 0);
        checks++; if (bus.mem_addr !== 8'd0) begin $display("[TB] FAIL fs_addr got %0d want 0", bus.mem_addr); errors++; end
        advance_to(1, 0);
        checks++; if (bus.mem_addr !== 8'd1) begin $display("[TB] FAIL h1_addr got %0d want 1", bus.mem_addr); errors++; end
        advance_to(2, 0);
        checks++; if ({R, G, B} !== 24'h000000) begin $display("[TB] FAIL pix0_rgb got %h want 000000", {R, G, B}); errors++; end
        checks++; if (pix_valid !== 1'b1) begin $display("[TB] FAIL pix0_pv got %b want 1", pix_valid); errors++; end
        advance_to(3, 0);
        checks++; if (R !== 8'h01) begin $display("[TB] FAIL pix1_r got %h want 01", R); errors++; end
        advance_to(7, 0);
        checks++; if ({R, G, B} !== 24'hA5A5A5) begin $display("[TB] FAIL pix5_rgb got %h want a5a5a5", {R, G, B}); errors++; end
        advance_to(9, 0);
        checks++; if (G !== 8'h77) begin $display("[TB] FAIL pix7_g got %h want 77", G); errors++; end
        advance_to(11, 0);
        checks++; if (B !== 8'h09) begin $display("[TB] FAIL pix9_b got %h want 09", B); errors++; end
        advance_to(41, 0);
        checks++; if (R !== 8'h27 || pix_valid !== 1'b1) begin $display("[TB] FAIL pix39_r got %h/%b want 27/1", R, pix_valid); errors++; end
        advance_to(42, 0);
        checks++; if (R !== 8'h00 || pix_valid !== 1'b0) begin $display("[TB] FAIL hblank_pv got %h/%b want 00/0", R, pix_valid); errors++; end
        advance_to(0, 1);
        checks++; if (bus.mem_addr !== 8'd40) begin $display("[TB] FAIL line1_addr got %0d want 40", bus.mem_addr); errors++; end
    endtask

    task automatic test_window_end();
        advance_to(39, 3);
        checks++; if (bus.mem_addr !== 8'd159) begin $display("[TB] FAIL last_addr got %0d want 159", bus.mem_addr); errors++; end
        advance_to(40, 3);
        checks++; if (bus.mem_addr !== 8'd0) begin $display("[TB] FAIL wrap_addr got %0d want 0", bus.mem_addr); errors++; end
        advance_to(41, 3);
        checks++; if (R !== 8'h9F || pix_valid !== 1'b1) begin $display("[TB] FAIL last_pix got %h/%b want 9f/1", R, pix_valid); errors++; end
        advance_to(42, 3);
        checks++; if (pix_valid !== 1'b0) begin $display("[TB] FAIL after_last_pv got %b want 0", pix_valid); errors++; end
        advance_to(0, 4);
        checks++; if (bus.mem_addr !== 8'd0) begin $display("[TB] FAIL vblank_addr got %0d want 0", bus.mem_addr); errors++; end
        advance_to(1, 4);
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL no_start_fr got %b want 1", frame_ready); errors++; end
        advance_to(0, 0);
        checks++; if (bus.mem_addr !== 8'd0) begin $display("[TB] FAIL next_fs_addr got %0d want 0", bus.mem_addr); errors++; end
        advance_to(2, 0);
        checks++; if (R !== 8'h00 || pix_valid !== 1'b1) begin $display("[TB] FAIL next_fs_pix got %h/%b want 00/1", R, pix_valid); errors++; end
    endtask

    task automatic test_start();
        advance_to(10, 2);
        bus.proc_start = 1'b1; bus.proc_done = 1'b1;
        #1;
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL start_mid_fr got %b want 1", frame_ready); errors++; end
        advance_to(11, 2);
        bus.proc_start = 1'b0; bus.proc_done = 1'b0;
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL start_ignored_fr got %b want 1", frame_ready); errors++; end
        advance_to(0, 4);
        advance_to(1, 4);
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL stale_start_fr got %b want 1", frame_ready); errors++; end
        bus.proc_start = 1'b1; bus.proc_req = 1'b1; bus.proc_addr = 8'd200; bus.proc_wdata = 8'h11;
        advance_to(0, 4);
        checks++; if (frame_ready !== 1'b1 || bus.proc_gnt !== 1'b0) begin $display("[TB] FAIL we_cycle got fr=%b gnt=%b want 1/0", frame_ready, bus.proc_gnt); errors++; end
        advance_to(1, 4);
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL reproc_fr got %b want 0", frame_ready); errors++; end
        checks++; if (bus.proc_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin $display("[TB] FAIL reproc_gnt got %b/%b want 1/1", bus.proc_gnt, bus.mem_we); errors++; end
        checks++; if (bus.mem_addr !== 8'd200) begin $display("[TB] FAIL reproc_addr got %0d want 200", bus.mem_addr); errors++; end
        bus.proc_done = 1'b1;
        advance_to(2, 4);
        bus.proc_done = 1'b0; bus.proc_req = 1'b0;
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL held_sync_fr got %b want 0", frame_ready); errors++; end
        advance_to(1, 0);
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL held_show_fr got %b want 1", frame_ready); errors++; end
        advance_to(20, 2);
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL held_mid_fr got %b want 1", frame_ready); errors++; end
        advance_to(0, 4);
        checks++; if (frame_ready !== 1'b1) begin $display("[TB] FAIL held_we_fr got %b want 1", frame_ready); errors++; end
        advance_to(1, 4);
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL held_reentry_fr got %b want 0", frame_ready); errors++; end
        bus.proc_start = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.proc_done = 1'b1;
        advance_to(2, 4);
        bus.proc_done = 1'b0;
        advance_to(1, 0);
        advance_to(12, 2);
        checks++; if (pix_valid !== 1'b1 || frame_ready !== 1'b1) begin $display("[TB] FAIL pre_reset got pv=%b fr=%b want 1/1", pix_valid, frame_ready); errors++; end
        bus.proc_req = 1'b1; bus.proc_addr = 8'd200;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({R, G, B} !== 24'd0 || pix_valid !== 1'b0) begin $display("[TB] FAIL async_rgb got %h/%b want 000000/0", {R, G, B}, pix_valid); errors++; end
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL async_fr got %b want 0", frame_ready); errors++; end
        checks++; if (bus.mem_addr !== 8'd0 || bus.proc_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin $display("[TB] FAIL async_mem got addr=%0d gnt=%b we=%b want 0/0/0", bus.mem_addr, bus.proc_gnt, bus.mem_we); errors++; end
        advance_to(20, 2);
        rst_n = 1'b1;
        #1;
        checks++; if (frame_ready !== 1'b0 || bus.proc_gnt !== 1'b1) begin $display("[TB] FAIL post_reset got fr=%b gnt=%b want 0/1", frame_ready, bus.proc_gnt); errors++; end
        checks++; if (bus.mem_addr !== 8'd200) begin $display("[TB] FAIL post_reset_addr got %0d want 200", bus.mem_addr); errors++; end
        bus.proc_req = 1'b0;
        advance_to(37, 2);
        advance_to(39, 2);
`ifdef TEST_PATTERN_EN
        checks++; if (R !== 8'd37 || pix_valid !== 1'b1) begin $display("[TB] FAIL pattern_pix got %0d/%b want 37/1", R, pix_valid); errors++; end
`else
        checks++; if (R !== 8'd0 || pix_valid !== 1'b0) begin $display("[TB] FAIL proc_pix got %0d/%b want 0/0", R, pix_valid); errors++; end
`endif
        checks++; if (frame_ready !== 1'b0) begin $display("[TB] FAIL proc_fr got %b want 0", frame_ready); errors++; end
    endtask

    initial begin
        h = 10; v = 4;
        H_Count_Value = 10'(h); V_Count_Value = 10'(v);
        rst_n = 1'b0; preload = 1'b1;
        bus.proc_req = 1'b0; bus.proc_addr = '0; bus.proc_wdata = '0;
        bus.proc_done = 1'b0; bus.proc_start = 1'b0;
        test_reset();
        test_write();
        test_sync();
        test_show();
        test_window_end();
        test_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_mem_scheduler.md
Name: result_mem_scheduler

Overview:
- Sequences the single-port 8-bit result memory between the image-processing engine (writer) and the VGA display path (reader).
- The processing engine owns the memory until it signals done. The scheduler then waits for a frame boundary and streams the IMG_W x IMG_H result window, in raster order, to R/G/B as grayscale.
- A new processing pass is admitted only at end of the displayed window, so a frame is never torn.

Parameters:
- IMG_W, 480, displayed window width in pixels (H_Count_Value < IMG_W)
- IMG_H, 320, displayed window height in lines (V_Count_Value < IMG_H)
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- DATA_W, 8, memory data width; one gray pixel per word

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- H_Count_Value  in  10  horizontal VGA counter
- V_Count_Value  in  10  vertical VGA counter
- proc_req  in  1  processing engine write request, one word per cycle
- proc_addr  in  ADDR_W  write address
- proc_wdata  in  DATA_W  write data
- proc_done  in  1  one-cycle pulse: processing pass complete (Done640 semantics)
- proc_start  in  1  level: request a new processing pass
- proc_gnt  out  1  write accepted this cycle
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address
- R, G, B  out  8 each  pixel colour
- pix_valid  out  1  R/G/B carry memory data
- frame_ready  out  1  high while in SHOW

Behaviour:
- Reset (async, rst_n=0), all values hold until release:
  - state=PROC; rd_addr=0.
  - R=G=B=0; pix_valid=0; frame_ready=0.
  - proc_gnt=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Window definition: win = (H_Count_Value < IMG_W) && (V_Count_Value < IMG_H).
- Frame start: fs = (H_Count_Value==0 && V_Count_Value==0).
- Window end: we = (H_Count_Value==0 && V_Count_Value==IMG_H).
- PROC state:
  - Memory outputs are combinational: proc_gnt = proc_req; mem_we = proc_req; mem_addr = proc_addr; mem_wdata = proc_wdata.
  - proc_done -> SYNC. A write presented in the same cycle as proc_done is still granted.
- SYNC state:
  - proc_gnt=0; mem_we=0.
  - On fs -> SHOW, with rd_addr loaded to 0.
- SHOW state:
  - frame_ready=1; proc_gnt=0; mem_we=0; mem_addr=rd_addr.
  - Each cycle with win=1, rd_addr increments. Once rd_addr reaches IMG_W*IMG_H-1, it wraps to 0.
  - rd_addr is also forced to 0 on every fs, so misalignment self-corrects each frame.
  - If proc_start=1 when we occurs -> PROC. No read is in flight at that point because win=0.
  - proc_start at any other time is ignored until the next we.
- Read pipeline (fixed 2-cycle latency, window cycle to output):
  - Cycle t: win=1, address issued.
  - Cycle t+1: mem_rdata valid; rd_v (registered win & SHOW) = 1.
  - Edge ending t+1: R=G=B=mem_rdata, pix_valid=1.
  - When rd_v=0: R=G=B=0, pix_valid=0. Outputs are never X.
- proc_done is ignored outside PROC.
- Reset asserted mid-SHOW or mid-write: immediate return to reset values; the engine must re-issue the pass.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined: while state != SHOW, window pixels (same 2-cycle latency) output R=G=B=H_Count_Value[7:0] with pix_valid=1.
- Undefined: pixels output 0 with pix_valid=0 while state != SHOW.
- Memory arbitration is identical in both cases.

Test Plan:
1. Reset release; proc_req=1, proc_addr=5, proc_wdata=8'hA5 -> same cycle: proc_gnt=1, mem_we=1, mem_addr=5, mem_wdata=8'hA5; R/G/B=0, frame_ready=0.
2. proc_done pulse at H=100,V=50 -> SYNC; mem_we=0; frame_ready rises on the cycle after the first fs (H=0,V=0); proc_req then yields proc_gnt=0.
3. SHOW with memory preloaded mem[k]=k[7:0] -> at H=0,V=0 mem_addr=0; at H=2,V=0 (2 cycles later) R=G=B=8'h00, pix_valid=1; at H=3 R=8'h01; at H=0,V=1 mem_addr=480.
4. Counters at H=480..799 or V>=320 -> rd_addr holds at 153600 mod wrap, pix_valid=0 two cycles after leaving the window; last window pixel (479,319) reads addr 153599, next fs reads addr 0.
5. proc_start=1 asserted at H=10,V=100 -> stays SHOW; at H=0,V=320 -> PROC, proc_gnt follows proc_req; proc_done plus proc_start held -> no re-entry to PROC before the next window end.
6. rst_n=0 mid-SHOW at H=200,V=150 -> outputs 0 asynchronously; after release state=PROC, frame_ready=0; with TEST_PATTERN_EN, window pixel at H=37 shows R=8'd37, pix_valid=1.
